// File: rtl/mem_port_arbiter_if.sv
// Memory bus between the port arbiter (master) and the memory (slave):
// request channel with valid/ready, response channel with valid only.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64
);
  logic              bus_req_valid;
  logic              bus_req_ready;
  logic              bus_req_we;
  logic [ADDR_W-1:0] bus_req_addr;
  logic [DATA_W-1:0] bus_req_wdata;
  logic              bus_resp_valid;
  logic [DATA_W-1:0] bus_resp_data;

  modport master (
    output bus_req_valid, bus_req_we, bus_req_addr, bus_req_wdata,
    input  bus_req_ready, bus_resp_valid, bus_resp_data
  );

  modport slave (
    input  bus_req_valid, bus_req_we, bus_req_addr, bus_req_wdata,
    output bus_req_ready, bus_resp_valid, bus_resp_data
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory bus between instruction fetch and the MEM stage; each access
// runs IDLE -> ISSUE -> WAIT -> RESP, with bounded MEM priority over IF.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W       = 64,
  parameter int unsigned DATA_W       = 64,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic              mem_done,
  output logic [DATA_W-1:0] mem_rdata,
  mem_port_arbiter_if.master bus,
  output logic              stall_if,
  output logic              stall_mem
);

  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;
  typedef enum logic {OWN_IF = 1'b0, OWN_MEM = 1'b1} owner_e;

  state_e            state_q,     state_d;
  owner_e            owner_q,     owner_d;
  logic              we_q,        we_d;
  logic [ADDR_W-1:0] addr_q,      addr_d;
  logic [DATA_W-1:0] wdata_q,     wdata_d;
  logic [CNT_W-1:0]  starve_q,    starve_d;
  logic              valid_q,     valid_d;
  logic              if_done_q,   if_done_d;
  logic              mem_done_q,  mem_done_d;
  logic [DATA_W-1:0] if_rdata_q,  if_rdata_d;
  logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;

  logic mem_any;
  logic grant_if;
  logic starve_full;

  assign mem_any     = mem_read | mem_write;
  assign starve_full = (starve_q == CNT_W'(STARVE_LIMIT));
  // MEM has priority unless IF has already waited out STARVE_LIMIT MEM grants.
  assign grant_if    = if_req & (~mem_any | starve_full);

  // Next-state, latched request and registered output logic.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    starve_d    = starve_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;

    case (state_q)
      S_IDLE: begin
        if (if_req | mem_any) begin
          state_d = S_ISSUE;
          if (grant_if) begin
            owner_d  = OWN_IF;
            we_d     = 1'b0;
            addr_d   = if_addr;
            wdata_d  = '0;
            starve_d = '0;
          end else begin
            owner_d = OWN_MEM;
            we_d    = mem_write;
            addr_d  = mem_addr;
            wdata_d = mem_wdata;
            if (!if_req) begin
              starve_d = '0;
            end else if (!starve_full) begin
              starve_d = starve_q + CNT_W'(1);
            end
          end
        end
      end
      S_ISSUE: begin
        if (bus.bus_req_ready) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.bus_resp_valid) begin
          state_d = S_RESP;
          if (!we_q) begin
            if (owner_q == OWN_IF) begin
              if_rdata_d = bus.bus_resp_data;
            end else begin
              mem_rdata_d = bus.bus_resp_data;
            end
          end
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    valid_d    = (state_d == S_ISSUE);
    if_done_d  = (state_d == S_RESP) && (owner_d == OWN_IF);
    mem_done_d = (state_d == S_RESP) && (owner_d == OWN_MEM);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      owner_q     <= OWN_IF;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      starve_q    <= '0;
      valid_q     <= 1'b0;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      starve_q    <= starve_d;
      valid_q     <= valid_d;
      if_done_q   <= if_done_d;
      mem_done_q  <= mem_done_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  assign bus.bus_req_valid = valid_q;
  assign bus.bus_req_we    = we_q;
  assign bus.bus_req_addr  = addr_q;
  assign bus.bus_req_wdata = wdata_q;

  assign if_done   = if_done_q;
  assign mem_done  = mem_done_q;
  assign if_rdata  = if_rdata_q;
  assign mem_rdata = mem_rdata_q;

  // Stalls release in the done cycle so the pipeline advances on the RESP edge.
  assign stall_if  = if_req & ~if_done_q;
  assign stall_mem = mem_any & ~mem_done_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed boundary cases followed by
// randomized IF/MEM traffic against a random-latency bus slave.
module tb_mem_port_arbiter;

  localparam int unsigned AW  = 64;
  localparam int unsigned DW  = 64;
  localparam int unsigned LIM = 4;

  typedef struct {
    bit            own_mem;
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } bus_exp_t;

  typedef struct {
    bit            own_mem;
    bit            we;
    logic [DW-1:0] data;
    int            cyc;
  } done_exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic          if_done;
  logic [DW-1:0] if_rdata;
  logic          mem_read = 1'b0;
  logic          mem_write = 1'b0;
  logic [AW-1:0] mem_addr = '0;
  logic [DW-1:0] mem_wdata = '0;
  logic          mem_done;
  logic [DW-1:0] mem_rdata;
  logic          stall_if;
  logic          stall_mem;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIM)) dut (
    .clk       (clk),
    .reset     (reset),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_done   (if_done),
    .if_rdata  (if_rdata),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_done  (mem_done),
    .mem_rdata (mem_rdata),
    .bus       (bus),
    .stall_if  (stall_if),
    .stall_mem (stall_mem)
  );

  bus_exp_t  exp_bus[$];
  done_exp_t exp_done[$];
  int        errors = 0;
  int        checks = 0;
  int        cyc = 0;
  int unsigned starve_m = 0;
  logic [DW-1:0] exp_if_rd = '0;
  logic [DW-1:0] exp_mem_rd = '0;

  // Bus slave configuration
  bit            slave_en = 1'b1;
  bit            cfg_rand = 1'b0;
  bit            cfg_data_en = 1'b0;
  int unsigned   cfg_hold = 0;
  int unsigned   cfg_rdly = 0;
  logic [DW-1:0] cfg_data = '0;
  bit            force_resp = 1'b0;
  logic [DW-1:0] force_data = '0;

  bit            s_pend = 1'b0;
  int unsigned   s_hold = 0;
  int unsigned   s_target = 0;
  int unsigned   s_rdly = 0;
  bus_exp_t      s_cur;
  done_exp_t     s_d;
  done_exp_t     m_d;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Bus slave: compares every presented request with the scoreboard, then
  // accepts after a programmable hold and responds after a programmable delay.
  initial begin
    bus.bus_req_ready  = 1'b0;
    bus.bus_resp_valid = 1'b0;
    bus.bus_resp_data  = '0;
    forever begin
      @(negedge clk);
      bus.bus_resp_valid = 1'b0;
      bus.bus_req_ready  = 1'b0;
      if (!slave_en || reset) begin
        s_pend = 1'b0;
        s_hold = 0;
        bus.bus_resp_valid = force_resp;
        bus.bus_resp_data  = force_data;
      end else if (s_pend) begin
        chk("valid_after_accept", 64'(bus.bus_req_valid), 64'(0));
        if (s_rdly == 0) begin
          s_d.own_mem = s_cur.own_mem;
          s_d.we      = s_cur.we;
          s_d.data    = cfg_data_en ? cfg_data : {$urandom, $urandom};
          s_d.cyc     = cyc;
          bus.bus_resp_valid = 1'b1;
          bus.bus_resp_data  = s_d.data;
          exp_done.push_back(s_d);
          s_pend = 1'b0;
        end else begin
          s_rdly--;
        end
      end else if (bus.bus_req_valid) begin
        if (exp_bus.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_bus_req: got addr %0h expected no request (cycle %0d)",
                   bus.bus_req_addr, cyc);
        end else begin
          s_cur = exp_bus[0];
          chk("bus_we", 64'(bus.bus_req_we), 64'(s_cur.we));
          chk("bus_addr", bus.bus_req_addr, s_cur.addr);
          if (s_cur.we) chk("bus_wdata", bus.bus_req_wdata, s_cur.wdata);
          if (s_hold == 0) s_target = cfg_rand ? $urandom_range(0, 3) : cfg_hold;
          if (s_hold >= s_target) begin
            bus.bus_req_ready = 1'b1;
            void'(exp_bus.pop_front());
            s_pend = 1'b1;
            s_hold = 0;
            s_rdly = cfg_rand ? $urandom_range(0, 2) : cfg_rdly;
          end else begin
            s_hold++;
          end
        end
      end else if (cfg_rand) begin
        bus.bus_req_ready = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 7) == 0) begin
          bus.bus_resp_valid = 1'b1;
          bus.bus_resp_data  = {$urandom, $urandom};
        end
      end
    end
  end

  // Completion monitor: done pulses, their timing, read data and stalls.
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        exp_if_rd  = '0;
        exp_mem_rd = '0;
      end else begin
        chk("stall_if", 64'(stall_if), 64'(if_req & ~if_done));
        chk("stall_mem", 64'(stall_mem), 64'((mem_read | mem_write) & ~mem_done));
        if (if_done | mem_done) begin
          chk("single_done", 64'(if_done & mem_done), 64'(0));
          if (exp_done.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL spurious_done: got if_done=%0d mem_done=%0d expected none (cycle %0d)",
                     if_done, mem_done, cyc);
          end else begin
            m_d = exp_done.pop_front();
            chk("done_owner_mem", 64'(mem_done), 64'(m_d.own_mem));
            chk("done_latency", 64'(cyc), 64'(m_d.cyc + 1));
            if (!m_d.we) begin
              if (m_d.own_mem) exp_mem_rd = m_d.data;
              else             exp_if_rd  = m_d.data;
            end
          end
        end
        chk("if_rdata", if_rdata, exp_if_rd);
        chk("mem_rdata", mem_rdata, exp_mem_rd);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  // Predicts the grant for the current IDLE cycle, then waits for its done pulse.
  task automatic grant_and_wait(output bit ok, output int dcyc, output bit got_if);
    bus_exp_t e;
    bit to_if;
    to_if = if_req && (!(mem_read || mem_write) || starve_m == LIM);
    got_if = to_if;
    e.own_mem = !to_if;
    if (to_if) begin
      e.we = 1'b0; e.addr = if_addr; e.wdata = '0;
      starve_m = 0;
    end else begin
      e.we = mem_write; e.addr = mem_addr; e.wdata = mem_wdata;
      starve_m = if_req ? ((starve_m >= LIM) ? LIM : starve_m + 1) : 0;
    end
    exp_bus.push_back(e);
    @(posedge clk); #1;
    // The arbiter must work from its latched copy from here on.
    if (to_if) if_addr = {$urandom, $urandom};
    else begin
      mem_addr  = {$urandom, $urandom};
      mem_wdata = {$urandom, $urandom};
    end
    ok = 1'b0;
    dcyc = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (to_if ? if_done : mem_done) begin
        ok = 1'b1;
        dcyc = cyc;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done for %s expected one within 40 cycles",
               to_if ? "IF" : "MEM");
    end
    @(posedge clk); #1;
  endtask

  task automatic new_if();
    if_req  = 1'b1;
    if_addr = {32'h0000_1000, $urandom} & ~64'h7;
  endtask

  task automatic new_mem();
    int unsigned k;
    k = $urandom_range(0, 2);
    mem_read  = (k != 1);
    mem_write = (k != 0);
    mem_addr  = {32'h0000_8000, $urandom} & ~64'h7;
    mem_wdata = {$urandom, $urandom};
  endtask

  initial begin
    bit ok;
    bit got_if;
    int dcyc;
    int c0;
    bus_exp_t e;

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // IF-only read: done on the fourth cycle with the response data.
    cfg_data_en = 1'b1; cfg_data = 64'hDEAD; cfg_hold = 0; cfg_rdly = 0;
    if_req = 1'b1; if_addr = 64'h100;
    c0 = cyc;
    grant_and_wait(ok, dcyc, got_if);
    chk("if_only_latency", 64'(dcyc - c0), 64'(3));
    if_req = 1'b0;
    @(negedge clk);
    chk("if_rdata_dead", if_rdata, 64'hDEAD);

    // Store with ready withheld for three cycles.
    @(posedge clk); #1;
    cfg_hold = 3;
    mem_write = 1'b1; mem_addr = 64'h40; mem_wdata = 64'h55;
    grant_and_wait(ok, dcyc, got_if);
    mem_write = 1'b0;
    @(negedge clk);
    chk("store_mem_rdata", mem_rdata, 64'h0);

    // Spurious responses while idle.
    @(posedge clk); #1;
    slave_en = 1'b0; force_resp = 1'b1; force_data = 64'hBAD0_BAD0;
    repeat (3) begin
      @(negedge clk);
      chk("idle_valid", 64'(bus.bus_req_valid), 64'(0));
    end
    @(posedge clk); #1;
    force_resp = 1'b0;
    repeat (2) @(posedge clk);
    #1 slave_en = 1'b1;

    // Reset in WAIT, late response afterwards.
    cfg_hold = 0; cfg_rdly = 0;
    if_req = 1'b1; if_addr = 64'h200;
    e.own_mem = 1'b0; e.we = 1'b0; e.addr = 64'h200; e.wdata = '0;
    exp_bus.push_back(e);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (s_pend) begin ok = 1'b1; break; end
    end
    chk("reset_case_accepted", 64'(ok), 64'(1));
    slave_en = 1'b0; reset = 1'b1; if_req = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_bus.delete(); exp_done.delete(); starve_m = 0;
    @(posedge clk); #1;
    force_resp = 1'b1; force_data = 64'hFACE;
    @(posedge clk); #1;
    force_resp = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("post_reset_valid", 64'(bus.bus_req_valid), 64'(0));
      chk("post_reset_if_done", 64'(if_done), 64'(0));
      chk("post_reset_if_rdata", if_rdata, 64'h0);
    end
    @(posedge clk); #1;
    slave_en = 1'b1; cfg_rand = 1'b1; cfg_data_en = 1'b0;

    // Random traffic; the first 40 slots keep both requesters busy to exercise starvation.
    new_if();
    new_mem();
    for (int s = 0; s < 160; s++) begin
      int unsigned p;
      grant_and_wait(ok, dcyc, got_if);
      if (!ok) break;
      p = (s < 40) ? 100 : 60;
      if (got_if) begin
        if ($urandom_range(0, 99) < p) new_if(); else if_req = 1'b0;
        if (!(mem_read || mem_write) && $urandom_range(0, 1) == 1) new_mem();
      end else begin
        if ($urandom_range(0, 99) < p) new_mem();
        else begin mem_read = 1'b0; mem_write = 1'b0; end
        if (!if_req && $urandom_range(0, 1) == 1) new_if();
      end
      if (!if_req && !(mem_read || mem_write)) begin
        if ($urandom_range(0, 1) == 1) new_if(); else new_mem();
      end
    end
    if_req = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("bus_queue_drained", 64'(exp_bus.size()), 64'(0));
    chk("done_queue_drained", 64'(exp_done.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
